audio_win_buf_ctrl: RTL and testbench

//   Controller wrapped around the 256x14 simple-dual-port sample RAM (1-cycle read

---
 rtl/audio_win_buf_ctrl.sv | 144 ++++++++++++++
 tb/tb_audio_win_buf_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/audio_win_buf_ctrl.sv
// Circular history buffer controller around a 256x14 simple-dual-port sample RAM.
// Streams the latest N samples oldest-first through a 2-entry valid/ready output FIFO.
module audio_win_buf_ctrl #(
    parameter int DATA_WIDTH = 14,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  frame_req_i,
    output logic                  frame_busy_o,
    output logic                  primed_o,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    input  logic                  out_ready_i,
    output logic                  frame_ovr_o,
    output logic                  ram_wr_en_o,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wr_data_o,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_rd_data_i
);

    localparam logic [ADDR_WIDTH:0] N_C    = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] LAST_C = N_C - (ADDR_WIDTH+1)'(1);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_READ = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wp_q, base_q;
    logic [ADDR_WIDTH:0]   fill_q, wcnt_q, rcnt_q;
    logic                  ovr_q;
    logic                  inflight_q, inflight_last_q;
    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic                  fifo_last_q [2];
    logic                  rptr_q, wptr_q;
    logic [1:0]            cnt_q;

    logic       primed_s, start_s, pop_s, last_acc_s, issue_s, ovr_set_s;
    logic [2:0] credit_s;

    // Handshake, credit and overwrite decode
    always_comb begin
        primed_s   = (fill_q == N_C);
        start_s    = (state_q == S_IDLE) && frame_req_i && primed_s;
        pop_s      = (cnt_q != 2'd0) && out_ready_i;
        last_acc_s = pop_s && fifo_last_q[rptr_q];
        // A beat leaving this cycle frees its slot, which keeps the stream at one beat per cycle.
        credit_s   = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        issue_s    = (state_q == S_READ) && (rcnt_q != N_C) && (credit_s < 3'd2);
        // A read issued in the same cycle returns the entry before the write lands.
        ovr_set_s  = (state_q == S_READ) && in_valid_i && (wcnt_q != N_C) &&
                     (wcnt_q >= (rcnt_q + {{ADDR_WIDTH{1'b0}}, issue_s}));
    end

    // Write pointer and fill level, active in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q   <= {ADDR_WIDTH{1'b0}};
            fill_q <= {(ADDR_WIDTH+1){1'b0}};
        end else if (in_valid_i) begin
            wp_q   <= wp_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            fill_q <= (fill_q == N_C) ? fill_q : fill_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start_s ? S_READ : S_IDLE;
            S_READ:  state_d = last_acc_s ? S_IDLE : S_READ;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and datapath outputs
    always_comb begin
        frame_busy_o  = (state_q == S_READ);
        primed_o      = primed_s;
        out_valid_o   = (cnt_q != 2'd0);
        out_data_o    = fifo_data_q[rptr_q];
        out_last_o    = fifo_last_q[rptr_q];
        frame_ovr_o   = last_acc_s && ovr_q;
        ram_wr_en_o   = in_valid_i;
        ram_wr_addr_o = wp_q;
        ram_wr_data_o = in_data_i;
        ram_rd_addr_o = base_q + rcnt_q[ADDR_WIDTH-1:0];
    end

    // Frame snapshot, read/write counters and sticky overwrite flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= {ADDR_WIDTH{1'b0}};
            wcnt_q <= {(ADDR_WIDTH+1){1'b0}};
            rcnt_q <= {(ADDR_WIDTH+1){1'b0}};
            ovr_q  <= 1'b0;
        end else if (start_s) begin
            base_q <= wp_q + {{(ADDR_WIDTH-1){1'b0}}, in_valid_i};
            wcnt_q <= {(ADDR_WIDTH+1){1'b0}};
            rcnt_q <= {(ADDR_WIDTH+1){1'b0}};
            ovr_q  <= 1'b0;
        end else if (state_q == S_READ) begin
            if (in_valid_i && (wcnt_q != N_C)) wcnt_q <= wcnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
            if (issue_s) rcnt_q <= rcnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
            if (last_acc_s)     ovr_q <= 1'b0;
            else if (ovr_set_s) ovr_q <= 1'b1;
        end
    end

    // RAM read pipeline and 2-entry output FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_data_q[0]  <= {DATA_WIDTH{1'b0}};
            fifo_data_q[1]  <= {DATA_WIDTH{1'b0}};
            fifo_last_q[0]  <= 1'b0;
            fifo_last_q[1]  <= 1'b0;
            rptr_q          <= 1'b0;
            wptr_q          <= 1'b0;
            cnt_q           <= 2'd0;
        end else begin
            inflight_q      <= issue_s;
            inflight_last_q <= issue_s && (rcnt_q == LAST_C);
            if (inflight_q) begin
                fifo_data_q[wptr_q] <= ram_rd_data_i;
                fifo_last_q[wptr_q] <= inflight_last_q;
                wptr_q              <= ~wptr_q;
            end
            if (pop_s) rptr_q <= ~rptr_q;
            cnt_q <= cnt_q + {1'b0, inflight_q} - {1'b0, pop_s};
        end
    end

endmodule

// File: tb/tb_audio_win_buf_ctrl.sv
// Directed bench for audio_win_buf_ctrl with a read-first behavioural RAM.
module tb_audio_win_buf_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, frame_req, out_ready;
    logic [13:0] in_data;
    logic        frame_busy, primed, out_valid, out_last, frame_ovr;
    logic [13:0] out_data;
    logic        ram_wr_en;
    logic [7:0]  ram_wr_addr, ram_rd_addr;
    logic [13:0] ram_wr_data, ram_rd_data;
    logic [13:0] mem [256];

    int checks = 0;
    int passes = 0;
    int exp_f [256];

    audio_win_buf_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_data_i(in_data), .frame_req_i(frame_req),
        .frame_busy_o(frame_busy), .primed_o(primed),
        .out_valid_o(out_valid), .out_data_o(out_data), .out_last_o(out_last),
        .out_ready_i(out_ready), .frame_ovr_o(frame_ovr),
        .ram_wr_en_o(ram_wr_en), .ram_wr_addr_o(ram_wr_addr), .ram_wr_data_o(ram_wr_data),
        .ram_rd_addr_o(ram_rd_addr), .ram_rd_data_i(ram_rd_data)
    );

    always #5 clk = ~clk;

    // Read-first synchronous RAM
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 14'(base + i);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_busy"}, frame_busy, 0);
        chk({tag, "_primed"}, primed, 0);
        chk({tag, "_ovr"}, frame_ovr, 0);
        chk({tag, "_wren"}, ram_wr_en, 0);
        chk({tag, "_wraddr"}, ram_wr_addr, 0);
        chk({tag, "_rdaddr"}, ram_rd_addr, 0);
    endtask

    // frame_req must already be 1; mode 0: ready=1, 1: random, 2: ready low for 20 steps
    task automatic read_frame(input int mode, input bit wr, input bit chk_data,
                              output bit ovr_seen, output int first_step, output int last_step);
        int n = 0, step = 0;
        bit stall_prev = 1'b0, done = 1'b0;
        logic [13:0] d_prev = 14'd0;
        logic l_prev = 1'b0;
        ovr_seen = 1'b0; first_step = -1; last_step = -1;
        while (!done && step < 2000) begin
            @(posedge clk);
            #1;
            step++;
            frame_req = 1'b0;
            in_valid  = wr;
            in_data   = 14'(5000 + step);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (step > 20);
            endcase
            #1;
            if (stall_prev) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, d_prev);
                chk("hold_last", out_last, l_prev);
            end
            if (out_valid && out_ready) begin
                if (n == 0) first_step = step;
                if (chk_data) chk("beat_data", out_data, exp_f[n]);
                chk("beat_last", out_last, (n == 255) ? 1 : 0);
                if (out_last) begin
                    ovr_seen  = frame_ovr;
                    last_step = step;
                    done      = 1'b1;
                end
                n++;
            end
            stall_prev = out_valid && !out_ready;
            d_prev     = out_data;
            l_prev     = out_last;
        end
        in_valid = 1'b0;
        if (!done) chk("frame_timeout", 0, 1);
    endtask

    initial begin
        bit ovr;
        int fs, ls, n;
        rst_n = 1'b0; in_valid = 1'b0; in_data = 14'd0; frame_req = 1'b0; out_ready = 1'b0;
        #12;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Unprimed request is dropped
        wr_n(100, 0);
        frame_req = 1'b1;
        tick();
        frame_req = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("unprimed_valid", out_valid, 0);
            chk("unprimed_busy", frame_busy, 0);
        end
        chk("unprimed_primed", primed, 0);

        // 300 samples, full-rate readout of 44..299
        wr_n(200, 100);
        chk("primed_300", primed, 1);
        for (int i = 0; i < 256; i++) exp_f[i] = 44 + i;
        frame_req = 1'b1;
        read_frame(0, 1'b0, 1'b1, ovr, fs, ls);
        chk("t1_ovr", ovr, 0);
        chk("t1_first_step", fs, 3);
        chk("t1_last_step", ls, 258);
        tick();
        chk("t1_busy_after", frame_busy, 0);

        // Random backpressure, same data
        frame_req = 1'b1;
        read_frame(1, 1'b0, 1'b1, ovr, fs, ls);
        chk("t3_ovr", ovr, 0);
        out_ready = 1'b1;
        tick();

        // Writes in lockstep with reads leave the frame intact
        frame_req = 1'b1;
        read_frame(0, 1'b1, 1'b1, ovr, fs, ls);
        chk("t4a_ovr", ovr, 0);
        tick();

        // Stalled readout lets writes overtake unread entries
        frame_req = 1'b1;
        read_frame(2, 1'b1, 1'b0, ovr, fs, ls);
        chk("t4b_ovr", ovr, 1);
        out_ready = 1'b1;
        tick();

        // Reset in the middle of a frame
        frame_req = 1'b1;
        n = 0;
        for (int s = 0; s < 400 && n < 100; s++) begin
            tick();
            frame_req = 1'b0;
            #1;
            if (out_valid && out_ready) n++;
        end
        chk("t6_reached_100", n, 100);
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        #20;
        rst_n = 1'b1;
        tick();
        chk("t6_busy", frame_busy, 0);
        chk("t6_valid", out_valid, 0);
        wr_n(255, 1000);
        chk("t6_primed_255", primed, 0);
        wr_n(1, 1255);
        chk("t6_primed_256", primed, 1);

        // Request coincides with a write at wp=255
        wr_n(255, 2000);
        chk("t5_wp", ram_wr_addr, 255);
        for (int i = 0; i < 255; i++) exp_f[i] = 2000 + i;
        exp_f[255] = 3000;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 14'd3000;
        frame_req = 1'b1;
        read_frame(0, 1'b0, 1'b1, ovr, fs, ls);
        chk("t5_ovr", ovr, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
